// File: rtl/wb_pkg.sv
// Shared widths and the pending-write entry type for the writeback stage.
package wb_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Dual-push / single-pop in-order FIFO of pending register writes.
// Port a is written ahead of port b when both push in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push_a,
    input  wb_entry_t                      entry_a,
    input  logic                           push_b,
    input  wb_entry_t                      entry_b,
    input  logic                           pop,
    output wb_entry_t                      head,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic [$clog2(DEPTH)-1:0]       head_ptr,
    output wb_entry_t [DEPTH-1:0]          entries
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] mem_q;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [PTR_W-1:0]      wr_ptr_b;
    logic                  pop_ok;

    // Port b lands one slot behind port a when both push together.
    assign wr_ptr_b = wr_ptr + PTR_W'(push_a);
    assign pop_ok   = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push_a) mem_q[wr_ptr]   <= entry_a;
            if (push_b) mem_q[wr_ptr_b] <= entry_b;
            wr_ptr  <= wr_ptr + PTR_W'(push_a) + PTR_W'(push_b);
            if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop_ok);
        end
    end

    assign head     = mem_q[rd_ptr];
    assign count    = count_q;
    assign head_ptr = rd_ptr;
    assign entries  = mem_q;

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: merges ALU and load results into one register-file write per cycle.
// Optional WB_FORWARD_EN adds a combinational lookup over all pending writes.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               mem_valid,
    output logic                               mem_ready,
    input  logic [ADDR_W-1:0]                  mem_dest,
    input  logic [DATA_W-1:0]                  mem_data,
    input  logic                               alu_valid,
    output logic                               alu_ready,
    input  logic [ADDR_W-1:0]                  alu_dest,
    input  logic [DATA_W-1:0]                  alu_data,
    output logic                               reg_write_en,
    output logic [ADDR_W-1:0]                  reg_write_dest,
    output logic [DATA_W-1:0]                  reg_write_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    pending_count,
    output logic                               fifo_full,
    output logic                               fifo_empty,
    input  logic [ADDR_W-1:0]                  fwd_addr,
    output logic                               fwd_hit,
    output logic [DATA_W-1:0]                  fwd_data
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    logic [CNT_W-1:0]           free_c;
    logic                       push_mem;
    logic                       push_alu;
    logic                       pop;
    wb_entry_t                  mem_entry;
    wb_entry_t                  alu_entry;
    wb_entry_t                  head;
    logic [PTR_W-1:0]           head_ptr;
    wb_entry_t [FIFO_DEPTH-1:0] fifo_entries;

    // Readiness looks only at registered occupancy, never at the same-cycle pop.
    assign free_c    = CNT_W'(FIFO_DEPTH) - pending_count;
    assign mem_ready = (free_c >= CNT_W'(1));
    assign alu_ready = mem_valid ? (free_c >= CNT_W'(2)) : (free_c >= CNT_W'(1));

    assign push_mem  = mem_valid && mem_ready;
    assign push_alu  = alu_valid && alu_ready;
    assign pop       = !fifo_empty;

    assign mem_entry = '{dest: mem_dest, data: mem_data};
    assign alu_entry = '{dest: alu_dest, data: alu_data};

    assign fifo_empty = (pending_count == '0);
    assign fifo_full  = (pending_count == CNT_W'(FIFO_DEPTH));

    // Loads occupy port a so they retire ahead of a same-cycle ALU result.
    wb_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_a   (push_mem),
        .entry_a  (mem_entry),
        .push_b   (push_alu),
        .entry_b  (alu_entry),
        .pop      (pop),
        .head     (head),
        .count    (pending_count),
        .head_ptr (head_ptr),
        .entries  (fifo_entries)
    );

    // Output register: strobe for one cycle per pop, address/data hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_en   <= 1'b0;
            reg_write_dest <= '0;
            reg_write_data <= '0;
        end else if (pop) begin
            reg_write_en   <= 1'b1;
            reg_write_dest <= head.dest;
            reg_write_data <= head.data;
        end else begin
            reg_write_en   <= 1'b0;
        end
    end

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0] fwd_idx;

    // Oldest first so the youngest matching write overrides earlier ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        if (reg_write_en && (reg_write_dest == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = reg_write_data;
        end
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            fwd_idx = head_ptr + PTR_W'(i);
            if ((i < 32'(pending_count)) && (fifo_entries[fwd_idx].dest == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_entries[fwd_idx].data;
            end
        end
    end
`else
    logic unused_fwd;

    assign fwd_hit    = 1'b0;
    assign fwd_data   = '0;
    assign unused_fwd = ^{fwd_addr, head_ptr, fifo_entries};
`endif

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Writeback stage directly upstream of register_file; sole driver of its write port (reg_write_en / reg_write_dest / reg_write_data).
- Accepts results from two producers, the ALU and the load unit, over valid/ready handshakes.
- Buffers results in a small in-order FIFO and retires exactly one register write per cycle.
- Decouples producer bursts (two results per cycle) from the single register-file write port.

Parameters:
- DATA_W, 16, register data width; must match register_file.
- ADDR_W, 4, register index width (16 registers).
- FIFO_DEPTH, 4, pending-write entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- mem_valid  input  1  load unit offers a result.
- mem_ready  output  1  stage accepts the load result this cycle.
- mem_dest  input  ADDR_W  destination register of the load result.
- mem_data  input  DATA_W  load result data.
- alu_valid  input  1  ALU offers a result.
- alu_ready  output  1  stage accepts the ALU result this cycle.
- alu_dest  input  ADDR_W  destination register of the ALU result.
- alu_data  input  DATA_W  ALU result data.
- reg_write_en  output  1  write strobe to register_file.
- reg_write_dest  output  ADDR_W  write address to register_file.
- reg_write_data  output  DATA_W  write data to register_file.
- pending_count  output  clog2(FIFO_DEPTH+1)  FIFO occupancy.
- fifo_full  output  1  pending_count == FIFO_DEPTH.
- fifo_empty  output  1  pending_count == 0.
- fwd_addr  input  ADDR_W  forwarding lookup address (see Optional Feature).
- fwd_hit  output  1  a pending write targets fwd_addr.
- fwd_data  output  DATA_W  newest pending data for fwd_addr.

Behaviour:
- Reset (synchronous, active-high), values at the first edge with rst=1:
  - FIFO pointers and count = 0.
  - reg_write_en = 0; reg_write_dest = 0; reg_write_data = 0.
  - fifo_empty = 1; fifo_full = 0.
  - Pending entries are discarded; there is no drain.
  - rst overrides any same-cycle handshake.
- Handshakes:
  - Transfer occurs when valid && ready at a rising edge.
  - Producers hold dest/data stable while valid && !ready.
  - free = FIFO_DEPTH - pending_count, taken from registered state only.
  - mem_ready = (free >= 1).
  - alu_ready = mem_valid ? (free >= 2) : (free >= 1).
  - ready never depends on the same-cycle pop, so a full FIFO stalls both producers for one cycle even while popping.
- Push ordering: when both producers transfer in the same cycle, the mem entry is written before the alu entry. Loads are older.
- Pop and output:
  - Each edge with the FIFO non-empty pops the head into the output register.
  - That cycle reg_write_en=1 with the head's dest and data.
  - Otherwise reg_write_en=0; dest and data hold their last values.
- Latency: a result accepted at edge N drives reg_write_en during cycle N+1 to N+2 when the FIFO was empty, and register_file captures it at edge N+2. There is no bypass around the FIFO.
- Throughput: up to 2 pushes and exactly 1 pop per cycle; the count is updated by pushes minus pop.
- Pointers wrap modulo FIFO_DEPTH; an extra wrap bit or the count distinguishes full from empty.
- Writes to the same dest retire in acceptance order, so the last one wins in register_file.
- pending_count counts FIFO entries only; the output register is not counted.

Optional Feature:
- Macro: WB_FORWARD_EN.
- Defined:
  - fwd_hit/fwd_data are combinational.
  - The search covers the output register (when reg_write_en=1) and all valid FIFO entries.
  - The youngest matching entry wins (tail side first, output register last).
  - fwd_data = 0 on a miss.
- Undefined: fwd_hit = 0 and fwd_data = 0 constantly; fwd_addr is ignored. Ports remain present.

Decomposition:
- Package wb_pkg holds:
  - DATA_W and ADDR_W localparams;
  - typedef wb_entry_t {dest[ADDR_W], data[DATA_W]}.
- One natural sub-module: wb_fifo.
  - Dual-push / single-pop FIFO of wb_entry_t, parameter DEPTH.
  - Exposes count and an entry array for the forwarding search.
- writeback_stage owns the ready logic, the output register and the forwarding mux.

Test Plan:
1. Single write: alu_valid=1, alu_dest=3, alu_data=16'hBEEF for one cycle from reset -> reg_write_en=1 for exactly one cycle, one cycle after acceptance, with dest=3 and data=BEEF; pending_count goes 1 then 0.
2. Dual push: mem {5, 16'h1234} and alu {6, 16'h5678} valid in the same cycle with the FIFO empty -> both ready=1; writes on consecutive cycles, dest 5 then dest 6.
3. Fill and backpressure: both producers valid every cycle with incrementing data, FIFO_DEPTH=4:
   - count reaches 4 and fifo_full=1;
   - alu_ready drops once free < 2, mem_ready drops at full;
   - no value is lost or duplicated; retire order equals acceptance order.
4. Wrap-around: 12 single ALU results, dest i mod 16, data 16'h0100+i -> 12 consecutive writes in exact sequence with no gaps after the first.
5. Reset mid-operation: 3 pending entries, rst=1 for one cycle -> the next cycle has reg_write_en=0, pending_count=0 and fifo_empty=1; no stale write ever appears afterwards.
6. With WB_FORWARD_EN: pend {7, 16'h0011} then {7, 16'h0022}:
   - fwd_addr=7 -> fwd_hit=1, fwd_data=16'h0022;
   - fwd_addr=9 -> fwd_hit=0, fwd_data=0.

   Without the macro: fwd_hit=0 throughout.
